// File: rtl/base_least_pkg.sv
// Shared types and the least-key replace rule for the least-family blocks.
package base_least_pkg;

    localparam int unsigned KEY_MAX_W = 64;

    typedef enum logic {
        FIRST = 1'b0,
        ACC   = 1'b1
    } state_e;

    // Replace the held entry when the new beat is real and strictly smaller, or nothing is held yet.
    function automatic logic least_take(
        input logic                 acc_dv,
        input logic [KEY_MAX_W-1:0] acc_k,
        input logic                 i_dv,
        input logic [KEY_MAX_W-1:0] i_k
    );
        return i_dv & (~acc_dv | (i_k < acc_k));
    endfunction

endpackage

// File: rtl/base_least_fold.sv
// Combinational next-accumulator: first-beat load or least-key fold with saturating count.
module base_least_fold
    import base_least_pkg::*;
#(
    parameter int unsigned kw        = 1,
    parameter int unsigned dw        = 1,
    parameter int unsigned aux_width = 1,
    parameter int unsigned cw        = 8
) (
    input  logic                 first_i,
    input  logic [kw-1:0]        acc_k_i,
    input  logic [dw-1:0]        acc_d_i,
    input  logic                 acc_dv_i,
    input  logic [aux_width-1:0] acc_aux_i,
    input  logic [cw-1:0]        acc_cnt_i,
    input  logic [kw-1:0]        beat_k_i,
    input  logic [dw-1:0]        beat_d_i,
    input  logic                 beat_dv_i,
    input  logic [aux_width-1:0] beat_aux_i,
    output logic [kw-1:0]        nxt_k_o,
    output logic [dw-1:0]        nxt_d_o,
    output logic                 nxt_dv_o,
    output logic [aux_width-1:0] nxt_aux_o,
    output logic [cw-1:0]        nxt_cnt_o
);

    localparam logic [cw-1:0] CNT_MAX = '1;

    logic take;

    always_comb begin
        take      = least_take(acc_dv_i, KEY_MAX_W'(acc_k_i), beat_dv_i, KEY_MAX_W'(beat_k_i));
        nxt_k_o   = acc_k_i;
        nxt_d_o   = acc_d_i;
        nxt_dv_o  = acc_dv_i;
        nxt_aux_o = acc_aux_i;
        nxt_cnt_o = acc_cnt_i;
        if (first_i) begin
            nxt_aux_o = beat_aux_i;
            nxt_dv_o  = beat_dv_i;
            nxt_k_o   = beat_dv_i ? beat_k_i : '0;
            nxt_d_o   = beat_dv_i ? beat_d_i : '0;
            nxt_cnt_o = cw'(beat_dv_i);
        end else begin
            if (take) begin
                nxt_k_o  = beat_k_i;
                nxt_d_o  = beat_d_i;
                nxt_dv_o = 1'b1;
            end
            if (beat_dv_i && (acc_cnt_i != CNT_MAX)) begin
                nxt_cnt_o = acc_cnt_i + cw'(1);
            end
        end
    end

endmodule

// File: rtl/base_least_reduce.sv
// Folds each i_last-terminated beat group into its least-key beat plus a valid-beat count.
module base_least_reduce
    import base_least_pkg::*;
#(
    parameter int unsigned kw        = 1,
    parameter int unsigned dw        = 1,
    parameter int unsigned aux_width = 1,
    parameter int unsigned cw        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [kw-1:0]        i_k,
    input  logic [dw-1:0]        i_d,
    input  logic                 i_dv,
    input  logic [aux_width-1:0] i_aux,
    input  logic                 i_last,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [kw-1:0]        o_k,
    output logic [dw-1:0]        o_d,
    output logic                 o_dv,
    output logic [aux_width-1:0] o_aux,
    output logic [cw-1:0]        o_cnt
);

    state_e                 state_q, state_d;
    logic [kw-1:0]          acc_k_q, acc_k_d;
    logic [dw-1:0]          acc_d_q, acc_d_d;
    logic                   acc_dv_q, acc_dv_d;
    logic [aux_width-1:0]   acc_aux_q, acc_aux_d;
    logic [cw-1:0]          acc_cnt_q, acc_cnt_d;
    logic                   o_v_q, o_v_d;
    logic [kw-1:0]          o_k_q, o_k_d;
    logic [dw-1:0]          o_d_q, o_d_d;
    logic                   o_dv_q, o_dv_d;
    logic [aux_width-1:0]   o_aux_q, o_aux_d;
    logic [cw-1:0]          o_cnt_q, o_cnt_d;

    logic [kw-1:0]          fold_k;
    logic [dw-1:0]          fold_d;
    logic                   fold_dv;
    logic [aux_width-1:0]   fold_aux;
    logic [cw-1:0]          fold_cnt;
    logic                   accept_c;

    base_least_fold #(
        .kw        (kw),
        .dw        (dw),
        .aux_width (aux_width),
        .cw        (cw)
    ) u_fold (
        .first_i    (state_q == FIRST),
        .acc_k_i    (acc_k_q),
        .acc_d_i    (acc_d_q),
        .acc_dv_i   (acc_dv_q),
        .acc_aux_i  (acc_aux_q),
        .acc_cnt_i  (acc_cnt_q),
        .beat_k_i   (i_k),
        .beat_d_i   (i_d),
        .beat_dv_i  (i_dv),
        .beat_aux_i (i_aux),
        .nxt_k_o    (fold_k),
        .nxt_d_o    (fold_d),
        .nxt_dv_o   (fold_dv),
        .nxt_aux_o  (fold_aux),
        .nxt_cnt_o  (fold_cnt)
    );

    // Ready only looks at the output slot, so a stalled result freezes the accumulator.
    assign i_r      = ~o_v_q | o_r;
    assign accept_c = i_v & i_r;

    always_comb begin
        state_d   = state_q;
        acc_k_d   = acc_k_q;
        acc_d_d   = acc_d_q;
        acc_dv_d  = acc_dv_q;
        acc_aux_d = acc_aux_q;
        acc_cnt_d = acc_cnt_q;
        o_v_d     = o_v_q;
        o_k_d     = o_k_q;
        o_d_d     = o_d_q;
        o_dv_d    = o_dv_q;
        o_aux_d   = o_aux_q;
        o_cnt_d   = o_cnt_q;
        if (o_v_q && o_r) begin
            o_v_d = 1'b0;
        end
        if (accept_c) begin
            acc_k_d   = fold_k;
            acc_d_d   = fold_d;
            acc_dv_d  = fold_dv;
            acc_aux_d = fold_aux;
            acc_cnt_d = fold_cnt;
            if (i_last) begin
                state_d = FIRST;
                o_v_d   = 1'b1;
                o_k_d   = fold_k;
                o_d_d   = fold_d;
                o_dv_d  = fold_dv;
                o_aux_d = fold_aux;
                o_cnt_d = fold_cnt;
            end else begin
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FIRST;
            acc_k_q   <= '0;
            acc_d_q   <= '0;
            acc_dv_q  <= 1'b0;
            acc_aux_q <= '0;
            acc_cnt_q <= '0;
            o_v_q     <= 1'b0;
            o_k_q     <= '0;
            o_d_q     <= '0;
            o_dv_q    <= 1'b0;
            o_aux_q   <= '0;
            o_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_k_q   <= acc_k_d;
            acc_d_q   <= acc_d_d;
            acc_dv_q  <= acc_dv_d;
            acc_aux_q <= acc_aux_d;
            acc_cnt_q <= acc_cnt_d;
            o_v_q     <= o_v_d;
            o_k_q     <= o_k_d;
            o_d_q     <= o_d_d;
            o_dv_q    <= o_dv_d;
            o_aux_q   <= o_aux_d;
            o_cnt_q   <= o_cnt_d;
        end
    end

    assign o_v   = o_v_q;
    assign o_k   = o_k_q;
    assign o_d   = o_d_q;
    assign o_dv  = o_dv_q;
    assign o_aux = o_aux_q;
    assign o_cnt = o_cnt_q;

endmodule

// File: tb/tb_base_least_reduce.sv
// Bench for base_least_reduce: group table, reset/backpressure sequences, random stream with scoreboard.
module tb_base_least_reduce;

    localparam int unsigned KW     = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned AW     = 4;
    localparam int unsigned CW     = 8;
    localparam int unsigned CW_SAT = 2;
    localparam int unsigned MAXB   = 6;
    localparam int          STALL_BUDGET = 60;

    typedef struct {
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        logic          dv;
        logic [AW-1:0] aux;
        int            cnt;
    } exp_t;

    typedef struct {
        int                        n;
        logic [MAXB-1:0]           dv;
        logic [MAXB-1:0][KW-1:0]   k;
        logic [MAXB-1:0][DW-1:0]   d;
        logic [AW-1:0]             aux;
        exp_t                      exp;
    } grp_t;

    logic          clk;
    logic          reset;
    logic          i_v;
    logic [KW-1:0] i_k;
    logic [DW-1:0] i_d;
    logic          i_dv;
    logic [AW-1:0] i_aux;
    logic          i_last;
    logic          o_r;

    logic              i_r_a, o_v_a, o_dv_a;
    logic [KW-1:0]     o_k_a;
    logic [DW-1:0]     o_d_a;
    logic [AW-1:0]     o_aux_a;
    logic [CW-1:0]     o_cnt_a;
    logic              i_r_b, o_v_b, o_dv_b;
    logic [KW-1:0]     o_k_b;
    logic [DW-1:0]     o_d_b;
    logic [AW-1:0]     o_aux_b;
    logic [CW_SAT-1:0] o_cnt_b;

    int   checks   = 0;
    int   errors   = 0;
    int   consumed = 0;
    int   or_mode  = 0;
    exp_t sb[$];
    grp_t vec [8];
    grp_t bp  [4];

    base_least_reduce #(.kw(KW), .dw(DW), .aux_width(AW), .cw(CW)) u_dut_a (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r_a), .i_k(i_k), .i_d(i_d),
        .i_dv(i_dv), .i_aux(i_aux), .i_last(i_last), .o_v(o_v_a), .o_r(o_r),
        .o_k(o_k_a), .o_d(o_d_a), .o_dv(o_dv_a), .o_aux(o_aux_a), .o_cnt(o_cnt_a)
    );

    base_least_reduce #(.kw(KW), .dw(DW), .aux_width(AW), .cw(CW_SAT)) u_dut_b (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r_b), .i_k(i_k), .i_d(i_d),
        .i_dv(i_dv), .i_aux(i_aux), .i_last(i_last), .o_v(o_v_b), .o_r(o_r),
        .o_k(o_k_b), .o_d(o_d_b), .o_dv(o_dv_b), .o_aux(o_aux_b), .o_cnt(o_cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (or_mode == 1)      o_r = 1'($urandom_range(0, 1));
        else if (or_mode == 2) o_r = 1'b0;
        else                   o_r = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic grp_t mk_grp(input int n, input logic [MAXB-1:0] dv,
                                    input logic [MAXB*KW-1:0] k, input logic [MAXB*DW-1:0] d,
                                    input logic [AW-1:0] aux, input logic [KW-1:0] ek,
                                    input logic [DW-1:0] ed, input logic edv, input int ecnt);
        grp_t g;
        g.n = n; g.dv = dv; g.k = k; g.d = d; g.aux = aux;
        g.exp.k = ek; g.exp.d = ed; g.exp.dv = edv; g.exp.aux = aux; g.exp.cnt = ecnt;
        return g;
    endfunction

    // Reference: first strictly-smallest real beat wins, aux from the first beat, unsaturated count.
    function automatic exp_t ref_fold(input grp_t g);
        exp_t e;
        e.k = '0; e.d = '0; e.dv = 1'b0; e.aux = g.aux; e.cnt = 0;
        for (int i = 0; i < g.n; i++) begin
            if (g.dv[i]) begin
                e.cnt++;
                if (!e.dv || (g.k[i] < e.k)) begin
                    e.k = g.k[i]; e.d = g.d[i]; e.dv = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Present one beat and return at posedge+2 after it has been accepted.
    task automatic send_beat(input logic [KW-1:0] k, input logic [DW-1:0] d, input logic dv,
                             input logic [AW-1:0] aux, input logic last);
        int waited;
        i_v = 1'b1; i_k = k; i_d = d; i_dv = dv; i_aux = aux; i_last = last;
        waited = 0;
        @(negedge clk);
        while (!i_r_a && waited < STALL_BUDGET) begin
            waited++;
            @(negedge clk);
        end
        if (!i_r_a) begin
            checks++; errors++;
            $display("FAIL accept_timeout: i_r=0 after %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        if (last && i_r_a) check1("latency_o_v", 32'({o_v_a, o_v_b}), 32'h3);
        #1;
        i_v = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_group(input grp_t g, input bit rand_aux);
        logic [AW-1:0] a;
        for (int i = 0; i < g.n; i++) begin
            a = (i == 0) ? g.aux : (rand_aux ? AW'($urandom) : '0);
            send_beat(g.k[i], g.d[i], g.dv[i], a, (i == g.n - 1));
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        check1("drain_queue_empty", 32'(sb.size()), 32'h0);
    endtask

    // Scoreboard: compare both instances whenever a result is consumed; held results must not move.
    exp_t mon_e;
    bit   held_valid = 1'b0;
    logic [KW-1:0] held_k;
    logic [DW-1:0] held_d;
    logic          held_dv;
    logic [AW-1:0] held_aux;
    logic [CW-1:0] held_cnt;
    int            sat_cnt;

    always @(negedge clk) begin
        if (reset) begin
            if (o_v_a && o_r) begin
                consumed++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got k=%0h d=%0h cnt=%0d, required no result",
                             o_k_a, o_d_a, o_cnt_a);
                end else begin
                    mon_e = sb.pop_front();
                    sat_cnt = (mon_e.cnt > 3) ? 3 : mon_e.cnt;
                    if (o_k_a !== mon_e.k || o_d_a !== mon_e.d || o_dv_a !== mon_e.dv ||
                        o_aux_a !== mon_e.aux || int'(o_cnt_a) != mon_e.cnt) begin
                        errors++;
                        $display("FAIL result_a: got k=%0h d=%0h dv=%0b aux=%0h cnt=%0d, required k=%0h d=%0h dv=%0b aux=%0h cnt=%0d",
                                 o_k_a, o_d_a, o_dv_a, o_aux_a, o_cnt_a,
                                 mon_e.k, mon_e.d, mon_e.dv, mon_e.aux, mon_e.cnt);
                    end
                    checks++;
                    if (o_v_b !== 1'b1 || o_k_b !== mon_e.k || o_d_b !== mon_e.d ||
                        o_dv_b !== mon_e.dv || o_aux_b !== mon_e.aux || int'(o_cnt_b) != sat_cnt) begin
                        errors++;
                        $display("FAIL result_sat: got v=%0b k=%0h d=%0h cnt=%0d, required v=1 k=%0h d=%0h cnt=%0d",
                                 o_v_b, o_k_b, o_d_b, o_cnt_b, mon_e.k, mon_e.d, sat_cnt);
                    end
                end
            end
            if (o_v_a && !o_r) begin
                if (held_valid) begin
                    checks++;
                    if (o_k_a !== held_k || o_d_a !== held_d || o_dv_a !== held_dv ||
                        o_aux_a !== held_aux || o_cnt_a !== held_cnt || i_r_a !== 1'b0 || i_r_b !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: got k=%0h d=%0h cnt=%0d i_r=%0b, required k=%0h d=%0h cnt=%0d i_r=0",
                                 o_k_a, o_d_a, o_cnt_a, i_r_a, held_k, held_d, held_cnt);
                    end
                end
                held_valid = 1'b1;
                held_k = o_k_a; held_d = o_d_a; held_dv = o_dv_a;
                held_aux = o_aux_a; held_cnt = o_cnt_a;
            end else begin
                held_valid = 1'b0;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        int   c0;
        grp_t g;

        vec[0] = mk_grp(3, 6'b000111, 48'h00_00_00_04_02_07, 48'h00_00_00_0C_0B_0A, 4'h5, 8'h02, 8'h0B, 1'b1, 3);
        vec[1] = mk_grp(4, 6'b000110, 48'h00_00_00_06_06_01, 48'h00_00_22_51_50_11, 4'h3, 8'h06, 8'h50, 1'b1, 2);
        vec[2] = mk_grp(3, 6'b000000, 48'h00_00_00_07_08_09, 48'h00_00_00_03_02_01, 4'hA, 8'h00, 8'h00, 1'b0, 0);
        vec[3] = mk_grp(1, 6'b000001, 48'h00_00_00_00_00_80, 48'h00_00_00_00_00_33, 4'h1, 8'h80, 8'h33, 1'b1, 1);
        vec[4] = mk_grp(1, 6'b000000, 48'h00_00_00_00_00_05, 48'h00_00_00_00_00_44, 4'h2, 8'h00, 8'h00, 1'b0, 0);
        vec[5] = mk_grp(6, 6'b111111, 48'h04_05_06_07_08_09, 48'h06_05_04_03_02_01, 4'hF, 8'h04, 8'h06, 1'b1, 6);
        vec[6] = mk_grp(3, 6'b000101, 48'h00_00_00_FF_00_FF, 48'h00_00_00_30_20_10, 4'h9, 8'hFF, 8'h10, 1'b1, 2);
        vec[7] = mk_grp(5, 6'b011111, 48'h00_02_01_01_03_03, 48'h00_05_04_03_02_01, 4'h4, 8'h01, 8'h03, 1'b1, 5);
        bp[0]  = mk_grp(1, 6'b000001, 48'h00_00_00_00_00_40, 48'h00_00_00_00_00_A1, 4'h1, 8'h40, 8'hA1, 1'b1, 1);
        bp[1]  = mk_grp(1, 6'b000001, 48'h00_00_00_00_00_10, 48'h00_00_00_00_00_A2, 4'h2, 8'h10, 8'hA2, 1'b1, 1);
        bp[2]  = mk_grp(1, 6'b000000, 48'h00_00_00_00_00_01, 48'h00_00_00_00_00_A3, 4'h3, 8'h00, 8'h00, 1'b0, 0);
        bp[3]  = mk_grp(1, 6'b000001, 48'h00_00_00_00_00_FE, 48'h00_00_00_00_00_A4, 4'h4, 8'hFE, 8'hA4, 1'b1, 1);

        clk = 1'b0; reset = 1'b0; o_r = 1'b1;
        i_v = 1'b0; i_k = '0; i_d = '0; i_dv = 1'b0; i_aux = '0; i_last = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check1("reset_outputs_a", 32'({o_v_a, o_k_a, o_d_a, o_dv_a, o_aux_a, o_cnt_a}), 32'h0);
        check1("reset_outputs_b", 32'({o_v_b, o_k_b, o_d_b, o_dv_b, o_aux_b, o_cnt_b}), 32'h0);
        check1("reset_i_r", 32'(i_r_a), 32'h1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;

        // Reset in the middle of a group discards the partial fold.
        send_beat(8'd5, 8'h11, 1'b1, 4'h7, 1'b0);
        send_beat(8'd3, 8'h22, 1'b1, 4'h0, 1'b0);
        reset = 1'b0;
        #1;
        check1("midreset_o_v_async", 32'(o_v_a), 32'h0);
        @(negedge clk);
        check1("midreset_o_v_held", 32'(o_v_a), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check1("postreset_o_v", 32'(o_v_a), 32'h0);
        @(posedge clk);
        #2;
        c0 = consumed;
        mon_e.k = 8'd9; mon_e.d = 8'h33; mon_e.dv = 1'b1; mon_e.aux = 4'h6; mon_e.cnt = 1;
        sb.push_back(mon_e);
        send_beat(8'd9, 8'h33, 1'b1, 4'h6, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check1("midreset_one_result", 32'(consumed - c0), 32'h1);
        check1("midreset_queue_empty", 32'(sb.size()), 32'h0);

        // Directed group table.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vec[i].exp);
            send_group(vec[i], 1'b0);
        end
        drain(20);

        // Backpressure: one pending result, four single-beat groups queued behind it.
        or_mode = 2; o_r = 1'b0;
        sb.push_back(vec[3].exp);
        send_group(vec[3], 1'b0);
        i_v = 1'b1; i_k = bp[0].k[0]; i_d = bp[0].d[0]; i_dv = bp[0].dv[0];
        i_aux = bp[0].aux; i_last = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check1("stall_i_r", 32'({i_r_a, i_r_b}), 32'h0);
        end
        @(posedge clk);
        #2;
        or_mode = 0; o_r = 1'b1;
        c0 = consumed;
        for (int i = 0; i < 4; i++) sb.push_back(bp[i].exp);
        for (int i = 0; i < 4; i++) send_group(bp[i], 1'b0);
        @(posedge clk);
        #1;
        check1("release_results_per_cycle", 32'(consumed - c0), 32'h5);
        check1("release_o_v_idle", 32'(o_v_a), 32'h0);
        #1;

        // Random groups with random downstream readiness.
        or_mode = 1;
        for (int gi = 0; gi < 100; gi++) begin
            g.n = $urandom_range(1, 6);
            g.dv = '0; g.k = '0; g.d = '0;
            for (int b = 0; b < g.n; b++) begin
                g.dv[b] = ($urandom_range(0, 3) != 0);
                g.k[b]  = KW'($urandom_range(0, 15));
                g.d[b]  = DW'($urandom);
            end
            g.aux = AW'($urandom);
            g.exp = ref_fold(g);
            sb.push_back(g.exp);
            send_group(g, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        or_mode = 0;
        drain(50);
        @(negedge clk);
        check1("final_o_v_idle", 32'(o_v_a), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
